// File: rtl/hash_pkg.sv
// Shared types and helpers for the hash engine memory arbiter.
package hash_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned AW_DEF  = 16;
    localparam int unsigned DW_DEF  = 32;
    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned MAX_PW  = 4;

    typedef struct packed {
        logic              found;
        logic [MAX_PW-1:0] idx;
    } pick_t;

    // First set bit of req at or above ptr, wrapping at n; lowest offset from ptr wins.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [MAX_PW-1:0]  ptr,
                                      input int unsigned        n);
        pick_t           r;
        logic [MAX_PW:0] j;
        r = '0;
        for (int k = int'(MAX_REQ) - 1; k >= 0; k--) begin
            j = {1'b0, ptr} + (MAX_PW+1)'(k);
            if (j >= (MAX_PW+1)'(n)) j = j - (MAX_PW+1)'(n);
            if ((k < int'(n)) && req[j[MAX_PW-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[MAX_PW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hash_mem_arbiter_pick.sv
// Round-robin winner selection: searches req upward from ptr with wrap-around.
module rr_priority_pick
    import hash_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PW      = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic               found_o,
    output logic [PW-1:0]      idx_o
);

    pick_t pick;

    always_comb begin
        pick    = rr_pick(MAX_REQ'(req_i), MAX_PW'(ptr_i), NUM_REQ);
        found_o = pick.found;
        idx_o   = PW'(pick.idx);
    end

endmodule

// File: rtl/hash_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between NUM_REQ hash engines.
module hash_mem_arbiter
    import hash_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    last,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DW-1:0]         rdata,
    output logic                  busy,
    output logic                  mem_clk,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_write_data,
    input  logic [DW-1:0]         mem_read_data
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [PW-1:0]      cur_q, cur_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               pick_found;
    logic [PW-1:0]      pick_idx;
    logic               beat;

    logic [AW-1:0]      addr_a  [NUM_REQ];
    logic [DW-1:0]      wdata_a [NUM_REQ];

    for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_split
        assign addr_a[i]  = req_addr[i*AW +: AW];
        assign wdata_a[i] = req_wdata[i*DW +: DW];
    end

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Memory port is gated by an active beat so mem_we never follows a stale grant.
    assign beat           = (state_q == BUSY) && req[cur_q];
    assign mem_we         = beat && req_we[cur_q];
    assign mem_addr       = beat ? addr_a[cur_q]  : '0;
    assign mem_write_data = beat ? wdata_a[cur_q] : '0;
    assign mem_clk        = clk;
    assign rdata          = mem_read_data;
    assign gnt            = gnt_q;
    assign rvalid         = rvalid_q;
    assign busy           = (state_q == BUSY);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rvalid_d = '0;
        cur_d    = cur_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    state_d = BUSY;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    cur_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                    if (!req_we[cur_q]) rvalid_d = NUM_REQ'(1) << cur_q;
                end
                if (!beat || last[cur_q] || (cnt_q == CW'(MAX_BURST - 1))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = (cur_q == PW'(NUM_REQ - 1)) ? '0 : cur_q + PW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rvalid_q <= '0;
            cur_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            cur_q    <= cur_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/hash_mem_arbiter.md
# hash_mem_arbiter

Round-robin arbiter that shares the single synchronous message/output memory port between `NUM_REQ` SHA-256 hash engines. Each engine requests the port, receives a one-hot grant, and runs a burst of read or write beats. The arbiter muxes the granted engine's address, write-enable and write data onto the memory, and returns read data tagged with a per-engine valid pulse. It sits between the hash engines and the testbench/top-level memory, replacing each engine's direct `mem_*` connection.

## Interface
Parameters:
- `NUM_REQ`, 4: number of hash engines; 2..16.
- `AW`, 16: memory address width.
- `DW`, 32: memory data width.
- `MAX_BURST`, 16: maximum beats per grant before forced release; 1..256.

Ports:
- `clk`  in  1: clock. Also driven out as `mem_clk`.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req`  in  NUM_REQ: per-engine request. Level; held for the whole burst.
- `last`  in  NUM_REQ: per-engine final-beat marker. Qualified by grant and req.
- `req_we`  in  NUM_REQ: per-engine write-enable for the current beat.
- `req_addr`  in  NUM_REQ x AW: per-engine beat address.
- `req_wdata`  in  NUM_REQ x DW: per-engine beat write data.
- `gnt`  out  NUM_REQ: one-hot registered grant.
- `rvalid`  out  NUM_REQ: one-hot pulse; `rdata` is valid for that engine this cycle.
- `rdata`  out  DW: `mem_read_data` broadcast to all engines.
- `busy`  out  1: high while in state BUSY.
- `mem_clk`  out  1: equals `clk`.
- `mem_we`  out  1: memory write-enable.
- `mem_addr`  out  AW: memory address.
- `mem_write_data`  out  DW: memory write data.
- `mem_read_data`  in  DW: memory read data, one cycle after address.

## Operation
- States: IDLE, BUSY.
- IDLE:
  - If `req` is nonzero, pick the winner. Search starts at index `ptr` and goes upward with wrap-around; the first set bit wins.
  - Register `gnt` to the winner's one-hot value, `cur` to its index and `cnt` to 0. Go to BUSY.
  - If `req` is zero, stay in IDLE with `gnt` at 0.
- BUSY, beat cycle (`req[cur]` high): one memory access occurs.
  - `mem_addr` = `req_addr[cur]`.
  - `mem_we` = `req_we[cur]`.
  - `mem_write_data` = `req_wdata[cur]`.
  - `cnt` increments.
- BUSY, release condition: the burst ends when any of these holds:
  - `last[cur]` is high on a beat.
  - The beat is number `MAX_BURST` (`cnt == MAX_BURST-1`).
  - `req[cur]` is low. This cycle is not a beat, and `mem_we` = 0.
- On release: `gnt` goes to 0 at the next edge, `ptr` = `cur+1` mod `NUM_REQ`, and the state returns to IDLE.
- Memory outputs are a combinational mux of the granted engine, gated by state BUSY and `req[cur]`.
  - Outside a beat: `mem_we` = 0, `mem_addr` = 0, `mem_write_data` = 0.
  - This keeps `mem_we` glitch-free with respect to `gnt`.
- Read return: on every read beat (beat with `req_we[cur]` = 0), register `rvalid` to one-hot(`cur`) for exactly the next cycle.
  - `rdata` = `mem_read_data` combinationally.
  - `rvalid` is still delivered if the grant was released on that beat.
- Write beats produce no `rvalid`.
- Engines whose `req` is high but `gnt` is low must hold their beat; no beat is consumed.
- A forced release (at `MAX_BURST`) does not lower the engine's `req`. That engine re-arbitrates at lowest priority and resumes the burst on a later grant.
- Width rules:
  - `cnt` is `$clog2(MAX_BURST+1)` bits.
  - `ptr` and `cur` are `$clog2(NUM_REQ)` bits, with explicit wrap at `NUM_REQ-1` (not power-of-two overflow).
  - Addresses are passed through unmodified; no address arithmetic occurs.

## Timing
- Reset values: state IDLE, `gnt` = 0, `rvalid` = 0, `busy` = 0, `ptr` = 0, `cnt` = 0, `cur` = 0.
  - Memory outputs are 0 because they are gated by state.
  - `rdata` follows the memory.
- Grant latency: with `req[i]` high before edge k and the arbiter in IDLE, `gnt[i]` is high after edge k. The first beat is sampled by the memory at edge k+1.
- Throughput:
  - One beat per cycle within a burst.
  - Exactly one dead cycle (IDLE) between consecutive grants, including the case where the same engine is re-granted.
- Read latency: `rvalid[i]` and valid `rdata` appear one cycle after the read beat's address cycle.
- `last` and `MAX_BURST` coinciding on the same beat cause a single release, with no extra cycle.
- Reset asserted mid-burst:
  - All registers return immediately to reset values; `gnt`, `rvalid` and `mem_we` drop asynchronously.
  - An in-flight read's `rvalid` is discarded.
- `req` change while not granted has no effect until the next IDLE arbitration.

## Structure
- Shared package `hash_pkg`:
  - `arb_state_t` (IDLE, BUSY).
  - Default `AW` and `DW` constants.
  - Function `rr_pick(req, ptr)` returning the winner index and a found flag.
- Natural sub-module: `rr_priority_pick`. It is the combinational rotate, priority-encode, un-rotate logic, parameterised by `NUM_REQ` and instantiated once.
- Everything else lives in `hash_mem_arbiter`.

## Test plan
- Single engine, burst of 3 reads:
  - Stimulus: engine 0 requests reads at addresses 0x10, 0x11, 0x12, with `last` on the third beat.
  - Required: `gnt` = 0001 for exactly 3 cycles.
  - Required: `rvalid[0]` pulses on 3 consecutive cycles carrying memory words 0x10 through 0x12.
  - Required: `gnt` = 0 on the next cycle.
- Simultaneous requests:
  - Stimulus: engines 0, 1 and 3 request one-beat writes at the same edge after reset.
  - Required: grants in order 0, 1, 3, each separated by one IDLE cycle.
  - Required: memory holds all three values.
- Fairness:
  - Stimulus: engines 0 and 2 request continuously with `last` on every beat.
  - Required: grants strictly alternate 0, 2, 0, 2 for 20 grants.
- Burst cap:
  - Stimulus: `MAX_BURST` = 4; engine 1 requests 10 writes with no `last`, while engine 2 is also requesting.
  - Required: engine 1 gets 4 beats, then engine 2 is granted, then engine 1 resumes at beat 5.
  - Required: 10 writes land at the correct addresses.
- Request drop:
  - Stimulus: engine 0 lowers `req` after 2 of 5 beats.
  - Required: `mem_we` = 0 in the drop cycle, `gnt` = 0 next cycle, and `ptr` = 1.
- Reset mid-burst:
  - Stimulus: assert `reset_n` low in the cycle after a read beat.
  - Required: `gnt`, `rvalid` and `mem_we` go to 0 asynchronously.
  - Required: after release, a fresh request is granted with the normal 1-cycle latency.
